pe_operand_dispatcher: RTL and testbench

Upstream feeder for the PE reducer in the sparse-convolution PE. It buffers a compressed, zero-skipped list of weights and a list of input activations, then walks their Cartesian product. Each pair is issued to the reducer as one lane of a 3-lane group: weight value, activation value and packed output address {k, x, y}. It pulses `o_start` per group and waits for the reducer's finish pulse before issuing the next group.

---
 rtl/pe_operand_dispatcher.sv | 155 +++++++++++++++
 tb/tb_pe_operand_dispatcher.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_operand_dispatcher.sv
// rtl/pe_operand_dispatcher.sv - buffers weight/activation lists and issues their product as 3-lane groups
module pe_operand_dispatcher #(
    parameter int W_DEPTH = 8,
    parameter int A_DEPTH = 8,
    parameter int LANES   = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_w_wr,
    input  logic [15:0]                    i_w_data,
    input  logic [6:0]                     i_w_k,
    input  logic                           i_a_wr,
    input  logic [15:0]                    i_a_data,
    input  logic [6:0]                     i_a_x,
    input  logic [6:0]                     i_a_y,
    input  logic                           i_go,
    input  logic                           i_red_finish,
    output logic                           o_start,
    output logic [20:0]                    o_addr [0:LANES-1],
    output logic [15:0]                    o_w    [0:LANES-1],
    output logic [15:0]                    o_ia   [0:LANES-1],
    output logic                           o_busy,
    output logic                           o_done,
    output logic [$clog2(W_DEPTH+1)-1:0]   o_w_cnt,
    output logic [$clog2(A_DEPTH+1)-1:0]   o_a_cnt
);

    localparam int WC = $clog2(W_DEPTH + 1);
    localparam int AC = $clog2(A_DEPTH + 1);
    localparam int WI = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int AI = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam logic [WC-1:0] W_FULL = WC'(W_DEPTH);
    localparam logic [AC-1:0] A_FULL = AC'(A_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_n;

    // Entries: weight = {data, k}; activation = {data, x, y}
    logic [22:0] w_mem [0:W_DEPTH-1];
    logic [29:0] a_mem [0:A_DEPTH-1];

    // Walk cursor: next pair to issue
    logic [WC-1:0] wi;
    logic [AC-1:0] ai;

    logic          w_accept, a_accept;
    logic [WC-1:0] w_eff, cw;
    logic [AC-1:0] a_eff, ca;
    logic [22:0]   w_ent;
    logic [29:0]   a_ent;
    logic [20:0]   nx_addr [0:LANES-1];
    logic [15:0]   nx_w    [0:LANES-1];
    logic [15:0]   nx_ia   [0:LANES-1];

    // Write qualification; effective counts fold in a same-cycle write so a write with i_go joins the walk
    always_comb begin
        w_accept = (state == S_IDLE) && i_w_wr && (i_w_data != 16'd0) && (o_w_cnt != W_FULL);
        a_accept = (state == S_IDLE) && i_a_wr && (i_a_data != 16'd0) && (o_a_cnt != A_FULL);
        w_eff    = o_w_cnt + {{(WC-1){1'b0}}, w_accept};
        a_eff    = o_a_cnt + {{(AC-1){1'b0}}, a_accept};
    end

    // List storage, written at index = count
    always_ff @(posedge i_clk) begin
        if (w_accept) w_mem[o_w_cnt[WI-1:0]] <= {i_w_data, i_w_k};
        if (a_accept) a_mem[o_a_cnt[AI-1:0]] <= {i_a_data, i_a_x, i_a_y};
    end

    // Build the next group from the cursor; lanes past the last pair stay zero
    always_comb begin
        cw    = wi;
        ca    = ai;
        w_ent = '0;
        a_ent = '0;
        for (int l = 0; l < LANES; l++) begin
            nx_w[l]    = '0;
            nx_ia[l]   = '0;
            nx_addr[l] = '0;
            if (cw < w_eff) begin
                w_ent = (w_accept && (cw == o_w_cnt)) ? {i_w_data, i_w_k} : w_mem[cw[WI-1:0]];
                a_ent = (a_accept && (ca == o_a_cnt)) ? {i_a_data, i_a_x, i_a_y} : a_mem[ca[AI-1:0]];
                nx_w[l]    = w_ent[22:7];
                nx_ia[l]   = a_ent[29:14];
                nx_addr[l] = {w_ent[6:0], a_ent[13:0]};
                if ((ca + AC'(1)) >= a_eff) begin
                    ca = '0;
                    cw = cw + WC'(1);
                end else begin
                    ca = ca + AC'(1);
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (i_go) state_n = ((w_eff != '0) && (a_eff != '0)) ? S_ISSUE : S_DONE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (i_red_finish) state_n = (wi < o_w_cnt) ? S_ISSUE : S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, counts, cursor and registered outputs; lanes load on every entry into ISSUE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            o_start <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_w_cnt <= '0;
            o_a_cnt <= '0;
            wi      <= '0;
            ai      <= '0;
            for (int l = 0; l < LANES; l++) begin
                o_w[l]    <= '0;
                o_ia[l]   <= '0;
                o_addr[l] <= '0;
            end
        end else begin
            state   <= state_n;
            o_start <= (state_n == S_ISSUE);
            o_busy  <= (state_n != S_IDLE);
            o_done  <= (state_n == S_DONE);
            if (state_n == S_ISSUE) begin
                wi <= cw;
                ai <= ca;
                for (int l = 0; l < LANES; l++) begin
                    o_w[l]    <= nx_w[l];
                    o_ia[l]   <= nx_ia[l];
                    o_addr[l] <= nx_addr[l];
                end
            end
            if (state == S_DONE) begin
                o_w_cnt <= '0;
                o_a_cnt <= '0;
                wi      <= '0;
                ai      <= '0;
            end else begin
                if (w_accept) o_w_cnt <= o_w_cnt + WC'(1);
                if (a_accept) o_a_cnt <= o_a_cnt + AC'(1);
            end
        end
    end

endmodule

// File: tb/tb_pe_operand_dispatcher.sv
// tb/tb_pe_operand_dispatcher.sv - self-checking bench for pe_operand_dispatcher
module tb_pe_operand_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_wr, a_wr, go, fin;
    logic [15:0] w_data, a_data;
    logic [6:0]  w_k, a_x, a_y;
    logic        o_start, o_busy, o_done;
    logic [20:0] o_addr [0:2];
    logic [15:0] o_w    [0:2];
    logic [15:0] o_ia   [0:2];
    logic [3:0]  o_w_cnt, o_a_cnt;

    always #5 clk = ~clk;

    pe_operand_dispatcher dut (
        .i_clk(clk), .i_rst(rst),
        .i_w_wr(w_wr), .i_w_data(w_data), .i_w_k(w_k),
        .i_a_wr(a_wr), .i_a_data(a_data), .i_a_x(a_x), .i_a_y(a_y),
        .i_go(go), .i_red_finish(fin),
        .o_start(o_start), .o_addr(o_addr), .o_w(o_w), .o_ia(o_ia),
        .o_busy(o_busy), .o_done(o_done), .o_w_cnt(o_w_cnt), .o_a_cnt(o_a_cnt)
    );

    typedef struct packed {
        logic [2:0][15:0] w;
        logic [2:0][15:0] ia;
        logic [2:0][20:0] addr;
    } grp_t;

    grp_t exp_q[$], obs_q[$];
    int   n_cmp = 0, n_bad = 0, n_start = 0, n_done = 0;
    time  t_start_prev = 0, t_start_last = 0;

    logic [15:0] mw[$], ma[$];
    logic [6:0]  mk[$], mx[$], my[$];

    function automatic grp_t cur_grp();
        grp_t g;
        for (int l = 0; l < 3; l++) begin
            g.w[l]    = o_w[l];
            g.ia[l]   = o_ia[l];
            g.addr[l] = o_addr[l];
        end
        return g;
    endfunction

    // Capture every issued group for the scoreboard
    always @(negedge clk) begin
        if (o_start) begin
            obs_q.push_back(cur_grp());
            n_start++;
            t_start_prev = t_start_last;
            t_start_last = $time;
        end
        if (o_done) n_done++;
    end

    task automatic wr_w(input logic [15:0] d, input logic [6:0] k);
        @(posedge clk); #1;
        w_wr = 1'b1; w_data = d; w_k = k;
        @(posedge clk); #1;
        w_wr = 1'b0;
        if (d != 16'd0 && mw.size() < 8) begin mw.push_back(d); mk.push_back(k); end
    endtask

    task automatic wr_a(input logic [15:0] d, input logic [6:0] x, input logic [6:0] y);
        @(posedge clk); #1;
        a_wr = 1'b1; a_data = d; a_x = x; a_y = y;
        @(posedge clk); #1;
        a_wr = 1'b0;
        if (d != 16'd0 && ma.size() < 8) begin ma.push_back(d); mx.push_back(x); my.push_back(y); end
    endtask

    task automatic pulse_finish();
        @(posedge clk); #1; fin = 1'b1;
        @(posedge clk); #1; fin = 1'b0;
    endtask

    // Expected groups from the model lists: weight outer, activation inner, zero-padded tail
    task automatic build_expected();
        grp_t g;
        int   lane;
        g = '0;
        lane = 0;
        foreach (mw[wi]) begin
            foreach (ma[ai]) begin
                g.w[lane]    = mw[wi];
                g.ia[lane]   = ma[ai];
                g.addr[lane] = {mk[wi], mx[ai], my[ai]};
                lane++;
                if (lane == 3) begin exp_q.push_back(g); g = '0; lane = 0; end
            end
        end
        if (lane != 0) exp_q.push_back(g);
        mw.delete(); mk.delete(); ma.delete(); mx.delete(); my.delete();
    endtask

    // Answer each o_start with a finish after 'gap' cycles until o_done
    task automatic finish_walk(input int gap);
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (o_done) break;
            if (cyc > 3000) begin
                n_cmp++; n_bad++;
                $display("FAIL walk_timeout got=no_done required=done");
                break;
            end
            if (o_start) begin
                repeat (gap) @(negedge clk);
                pulse_finish();
            end
        end
    endtask

    task automatic run_walk(input int gap);
        @(posedge clk); #1; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        finish_walk(gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        w_wr = 0; a_wr = 0; go = 0; fin = 0;
        w_data = 0; a_data = 0; w_k = 0; a_x = 0; a_y = 0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (o_start !== 1'b0) begin n_bad++; $display("FAIL reset_start got=%b required=0", o_start); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b required=0", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b required=0", o_done); end
        n_cmp++; if (o_w_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_wcnt got=%0d required=0", o_w_cnt); end
        n_cmp++; if (o_a_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_acnt got=%0d required=0", o_a_cnt); end
        n_cmp++; if (cur_grp() !== grp_t'(0)) begin n_bad++; $display("FAIL reset_lanes got=%h required=0", cur_grp()); end
        @(negedge clk); rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic test_basic();
        grp_t e;
        int   d0;
        wr_w(16'd15, 7'd0); wr_w(16'd16, 7'd1);
        wr_a(16'd3, 7'd0, 7'd0); wr_a(16'd2, 7'd1, 7'd1);
        @(negedge clk); #1;
        n_cmp++; if (o_w_cnt !== 4'd2) begin n_bad++; $display("FAIL basic_wcnt got=%0d required=2", o_w_cnt); end
        n_cmp++; if (o_a_cnt !== 4'd2) begin n_bad++; $display("FAIL basic_acnt got=%0d required=2", o_a_cnt); end
        build_expected();
        d0 = n_done;
        @(posedge clk); #1; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (o_start !== 1'b1) begin n_bad++; $display("FAIL basic_go_latency got=%b required=1", o_start); end
        e = exp_q[0];
        n_cmp++; if (cur_grp() !== e) begin n_bad++; $display("FAIL basic_group1 got=%h required=%h", cur_grp(), e); end
        pulse_finish();
        @(negedge clk); #1;
        n_cmp++; if (o_start !== 1'b1) begin n_bad++; $display("FAIL basic_finish_latency got=%b required=1", o_start); end
        pulse_finish();
        @(negedge clk); #1;
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL basic_done got=%b required=1", o_done); end
        @(negedge clk); #1;
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle got=%b required=0", o_busy); end
        n_cmp++; if ({o_w_cnt, o_a_cnt} !== 8'd0) begin n_bad++; $display("FAIL basic_cnt_clear got=%0d/%0d required=0/0", o_w_cnt, o_a_cnt); end
        n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL basic_done_pulses got=%0d required=1", n_done - d0); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_ngroups got=%0d required=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[0] !== e) begin n_bad++; $display("FAIL basic_group got=%h required=%h", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_zero_full();
        grp_t e;
        wr_w(16'd0, 7'd5);
        @(negedge clk); #1;
        n_cmp++; if (o_w_cnt !== 4'd0) begin n_bad++; $display("FAIL zero_skip got=%0d required=0", o_w_cnt); end
        for (int i = 0; i < 9; i++) wr_w(16'(100 + i), 7'(i + 20));
        @(negedge clk); #1;
        n_cmp++; if (o_w_cnt !== 4'd8) begin n_bad++; $display("FAIL full_cnt got=%0d required=8", o_w_cnt); end
        wr_a(16'd7, 7'd3, 7'd4);
        build_expected();
        run_walk(1);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL full_ngroups got=%0d required=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[0] !== e) begin n_bad++; $display("FAIL full_group got=%h required=%h", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_empty();
        int s0;
        wr_w(16'd5, 7'd2);
        mw.delete(); mk.delete();
        s0 = n_start;
        @(posedge clk); #1; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL empty_done got=%b required=1", o_done); end
        repeat (5) @(negedge clk);
        #1;
        n_cmp++; if (n_start !== s0) begin n_bad++; $display("FAIL empty_no_start got=%0d required=%0d", n_start, s0); end
        n_cmp++; if (o_w_cnt !== 4'd0) begin n_bad++; $display("FAIL empty_cnt_clear got=%0d required=0", o_w_cnt); end
        obs_q.delete();
    endtask

    task automatic test_stall();
        grp_t snap, e;
        int   s0;
        wr_w(16'd9, 7'd3); wr_a(16'd4, 7'd5, 7'd6);
        build_expected();
        s0 = n_start;
        @(posedge clk); #1; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        @(negedge clk); #1;
        snap = cur_grp();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (cur_grp() !== snap || o_start !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold c=%0d got=%h start=%b required=%h start=0", c, cur_grp(), o_start, snap);
            end
        end
        n_cmp++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL stall_starts got=%0d required=1", n_start - s0); end
        pulse_finish();
        finish_walk(0);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL stall_ngroups got=%0d required=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[0] !== e) begin n_bad++; $display("FAIL stall_group got=%h required=%h", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int s0;
        wr_w(16'd11, 7'd1); wr_w(16'd12, 7'd2);
        wr_a(16'd13, 7'd3, 7'd4); wr_a(16'd14, 7'd5, 7'd6);
        mw.delete(); mk.delete(); ma.delete(); mx.delete(); my.delete();
        @(posedge clk); #1; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if ({o_start, o_busy, o_done} !== 3'b000) begin n_bad++; $display("FAIL rstmid_ctrl got=%b required=000", {o_start, o_busy, o_done}); end
        n_cmp++; if ({o_w_cnt, o_a_cnt} !== 8'd0) begin n_bad++; $display("FAIL rstmid_cnt got=%0d/%0d required=0/0", o_w_cnt, o_a_cnt); end
        n_cmp++; if (cur_grp() !== grp_t'(0)) begin n_bad++; $display("FAIL rstmid_lanes got=%h required=0", cur_grp()); end
        @(negedge clk); rst = 1'b0;
        s0 = n_start;
        pulse_finish();
        repeat (5) @(negedge clk);
        #1;
        n_cmp++; if (n_start !== s0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_finish got=starts%0d busy%b required=starts%0d busy0", n_start, o_busy, s0); end
        obs_q.delete();
    endtask

    task automatic test_ignored();
        grp_t e;
        int   s0;
        wr_w(16'd15, 7'd0); wr_w(16'd16, 7'd1);
        wr_a(16'd3, 7'd0, 7'd0); wr_a(16'd2, 7'd1, 7'd1);
        build_expected();
        s0 = n_start;
        @(posedge clk); #1; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        @(negedge clk); #1;
        fin = 1'b1; go = 1'b1;
        w_wr = 1'b1; w_data = 16'd99; w_k = 7'd9;
        a_wr = 1'b1; a_data = 16'd77; a_x = 7'd7; a_y = 7'd7;
        @(posedge clk); #1;
        fin = 1'b0; go = 1'b0; w_wr = 1'b0; a_wr = 1'b0;
        @(posedge clk); #1;
        go = 1'b1; w_wr = 1'b1; a_wr = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; w_wr = 1'b0; a_wr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if ({o_w_cnt, o_a_cnt} !== {4'd2, 4'd2}) begin n_bad++; $display("FAIL ignored_cnt got=%0d/%0d required=2/2", o_w_cnt, o_a_cnt); end
        n_cmp++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL ignored_early_finish got=%0d required=1", n_start - s0); end
        pulse_finish();
        finish_walk(0);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL ignored_ngroups got=%0d required=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[0] !== e) begin n_bad++; $display("FAIL ignored_group got=%h required=%h", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        grp_t e;
        wr_w(16'h1234, 7'd10); wr_w(16'h0bcd, 7'd11);
        wr_a(16'd5, 7'd1, 7'd2);
        @(posedge clk); #1;
        go = 1'b1; a_wr = 1'b1; a_data = 16'd6; a_x = 7'd3; a_y = 7'd4;
        ma.push_back(16'd6); mx.push_back(7'd3); my.push_back(7'd4);
        @(posedge clk); #1;
        go = 1'b0; a_wr = 1'b0;
        build_expected();
        finish_walk(0);
        n_cmp++; if (t_start_last - t_start_prev !== 20) begin n_bad++; $display("FAIL b2b_period got=%0t required=20", t_start_last - t_start_prev); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL b2b_ngroups got=%0d required=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[0] !== e) begin n_bad++; $display("FAIL b2b_group got=%h required=%h", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        grp_t e;
        int   nw, na;
        for (int it = 0; it < 4; it++) begin
            nw = $urandom_range(1, 5);
            na = $urandom_range(1, 5);
            for (int i = 0; i < nw; i++) wr_w(16'($urandom_range(1, 65535)), 7'($urandom_range(0, 127)));
            for (int i = 0; i < na; i++) wr_a(16'($urandom_range(1, 65535)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            build_expected();
            run_walk($urandom_range(0, 2));
            n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_ngroups it=%0d got=%0d required=%0d", it, obs_q.size(), exp_q.size()); end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (obs_q[0] !== e) begin n_bad++; $display("FAIL rand_group it=%0d got=%h required=%h", it, obs_q[0], e); end
                void'(obs_q.pop_front());
            end
            obs_q.delete(); exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_full();
        test_empty();
        test_stall();
        test_reset_mid();
        test_ignored();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
